// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and helpers for the writeback arbiter
//
// Purpose : default widths, requester count, FIFO depth, requester index
//           names and the round-robin successor function.
// Ports   : none (package).

package wb_arbiter_pkg;

  localparam int ROB_ADDR_LEN  = 4;
  localparam int DATA_LEN      = 32;
  localparam int ADDR_LEN      = 32;

  localparam int WB_NUM_REQ    = 3;
  localparam int WB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_SLB = 2'd1,
    WB_SRC_AUX = 2'd2
  } wb_src_e;

  // Successor of requester g in a ring of n; wraps explicitly so n need not
  // be a power of two.
  function automatic int rr_next(input int g, input int n);
    return (g >= n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - single-requester skid FIFO with push, pop, count and flush
//
// Purpose : holds completed results of one execution unit until granted.
// Ports   : clk, rst            clock, synchronous active-high reset
//           rdy                 global enable; low freezes all state
//           flush               clears counts and pointers
//           push_valid_i/ready_o, push_data_i   producer handshake
//           pop_i               advance read pointer (caller guarantees non-empty)
//           head_o              entry at the read pointer
//           count_o             number of stored entries

module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             push_ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Ready looks only at the registered count, so a full FIFO stays not-ready
  // even when it is popped this cycle.
  assign push_ready_o = rdy && !flush && (count_q != CNT_W'(DEPTH));
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_i && rdy && !flush && (count_q != '0);

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (rdy) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin arbiter of execution results onto the ROB writeback port
//
// Purpose : one skid FIFO per execution unit; a round-robin pointer picks the
//           first non-empty FIFO and its head is registered onto wb_*.
//           A misbranch flush empties every FIFO.
// Ports   : clk, rst, rdy, flush        clock, sync reset, global enable, flush
//           req_valid/req_ready         per-unit handshake
//           req_robnum/data/need_jump/true_pc   flattened per-unit payload
//           wb_valid, wb_robnum, wb_data, wb_need_jump, wb_true_pc, wb_src
//                                       registered writeback

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = WB_NUM_REQ,
  parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter  int ROB_ADDR_W = ROB_ADDR_LEN,
  parameter  int DATA_W     = DATA_LEN,
  parameter  int ADDR_W     = ADDR_LEN,
  localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_ADDR_W-1:0] req_robnum,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_need_jump,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_true_pc,
  output logic                         wb_valid,
  output logic [ROB_ADDR_W-1:0]        wb_robnum,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         wb_need_jump,
  output logic [ADDR_W-1:0]            wb_true_pc,
  output logic [SRC_W-1:0]             wb_src
);

  localparam int ENT_W = ROB_ADDR_W + DATA_W + 1 + ADDR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ENT_W-1:0]   push_ent [NUM_REQ];
  logic [ENT_W-1:0]   head_ent [NUM_REQ];
  logic [CNT_W-1:0]   count    [NUM_REQ];
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] pop;

  logic               any_ne;
  int                 grant_int;
  int                 rr_int;
  logic [SRC_W-1:0]   grant_idx;
  logic [ENT_W-1:0]   grant_ent;
  logic               do_pop;

  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               wb_valid_q;
  logic [ENT_W-1:0]   wb_ent_q;
  logic [SRC_W-1:0]   wb_src_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign push_ent[i] = {req_robnum[i*ROB_ADDR_W +: ROB_ADDR_W],
                          req_data[i*DATA_W +: DATA_W],
                          req_need_jump[i],
                          req_true_pc[i*ADDR_W +: ADDR_W]};

    wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .flush        (flush),
      .push_valid_i (req_valid[i]),
      .push_data_i  (push_ent[i]),
      .push_ready_o (req_ready[i]),
      .pop_i        (pop[i]),
      .head_o       (head_ent[i]),
      .count_o      (count[i])
    );

    assign nonempty[i] = (count[i] != '0);
    assign pop[i]      = do_pop && (grant_idx == SRC_W'(i));
  end

  // Scan distances k = 0..NUM_REQ-1 from rr_ptr; requester i sits at distance
  // k when i == rr+k, or i == rr+k-NUM_REQ once the scan wraps.
  always_comb begin
    any_ne    = 1'b0;
    grant_int = 0;
    rr_int    = int'(rr_ptr_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_ne && nonempty[i] &&
            ((i == rr_int + k) || (i == rr_int + k - NUM_REQ))) begin
          any_ne    = 1'b1;
          grant_int = i;
        end
      end
    end
  end

  always_comb begin
    grant_ent = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_int == i) grant_ent = head_ent[i];
    end
  end

  assign grant_idx = SRC_W'(grant_int);
  assign do_pop    = rdy && !flush && any_ne;
  assign rr_ptr_d  = SRC_W'(rr_next(grant_int, NUM_REQ));

  // Data fields only load on a grant, so they keep the last writeback
  // while idle or flushed; rr_ptr survives a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_ent_q   <= '0;
      wb_src_q   <= '0;
    end else if (rdy) begin
      if (flush) begin
        wb_valid_q <= 1'b0;
      end else if (any_ne) begin
        wb_valid_q <= 1'b1;
        wb_ent_q   <= grant_ent;
        wb_src_q   <= grant_idx;
        rr_ptr_q   <= rr_ptr_d;
      end else begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign {wb_robnum, wb_data, wb_need_jump, wb_true_pc} = wb_ent_q;
  assign wb_src   = wb_src_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Arbitrates completed results from NUM_REQ execution units (ALU, load/store buffer, spare unit) onto the single writeback port of the reorder buffer, one result per cycle.
Each requester has a small skid FIFO and a valid/ready handshake. A round-robin pointer selects among non-empty FIFOs.
On a branch misprediction all queued results are discarded so no stale writeback reaches the reorder buffer.

Parameters:
NUM_REQ, 3, number of requesting units; index 0 = ALU, 1 = load/store buffer, 2 = spare.
FIFO_DEPTH, 2, entries per requester FIFO; power of two, minimum 2.
ROB_ADDR_W, 4, reorder-buffer tag width.
DATA_W, 32, result data width.
ADDR_W, 32, branch target width.

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; when low, all state holds
flush  in  1  misbranch flush from the reorder buffer
req_valid  in  NUM_REQ  per-unit result valid
req_ready  out  NUM_REQ  per-unit FIFO can accept
req_robnum  in  NUM_REQ*ROB_ADDR_W  flattened tags; unit i occupies slice [i*W +: W]
req_data  in  NUM_REQ*DATA_W  flattened result data
req_need_jump  in  NUM_REQ  branch-taken flag
req_true_pc  in  NUM_REQ*ADDR_W  flattened resolved target
wb_valid  out  1  registered writeback strobe
wb_robnum  out  ROB_ADDR_W  tag of the granted entry
wb_data  out  DATA_W  data of the granted entry
wb_need_jump  out  1  need_jump of the granted entry
wb_true_pc  out  ADDR_W  true_pc of the granted entry
wb_src  out  clog2(NUM_REQ)  index of the granted unit

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - all FIFO counts, read pointers and write pointers = 0;
  - rr_ptr = 0;
  - wb_valid = 0; wb_robnum, wb_data, wb_need_jump, wb_true_pc, wb_src = 0;
  - req_ready = all 1 in the cycle after reset.
- req_ready[i] = rdy && !flush && (count[i] != FIFO_DEPTH). It is combinational from registered count only.
  - A full FIFO reports not-ready even if it is popped in the same cycle. This is deliberate: no ready-from-pop path.
- Push: on a clk edge with req_valid[i] && req_ready[i], the entry is written at wr_ptr[i]. wr_ptr wraps mod FIFO_DEPTH.
  - If req_valid[i] is asserted while req_ready[i] is low, the producer holds the entry; it is not dropped.
- Grant (combinational from registered state): g = the first i with count[i] != 0, scanning i = rr_ptr, rr_ptr+1, … mod NUM_REQ.
- Pop, on a clk edge when rdy && !flush and some FIFO is non-empty:
  - the head of FIFO g is registered onto the wb_* outputs with wb_valid = 1 and wb_src = g;
  - rd_ptr[g] advances;
  - rr_ptr = (g+1) mod NUM_REQ. Wrap is explicit; do not rely on power-of-two NUM_REQ.
- No non-empty FIFO: wb_valid = 0, rr_ptr unchanged, wb_* data fields hold their previous values.
- Latency: a result pushed at edge N appears on wb_* at edge N+1 at the earliest.
  - An entry pushed at edge N is not grantable until edge N+1, because grant uses registered count.
  - wb_valid is a one-cycle pulse per entry; sustained throughput is 1 result/cycle total.
- Same-FIFO push and pop in one cycle: count is unchanged, both pointers advance.
- Flush (rdy high):
  - all counts and pointers clear, wb_valid = 0 at the next edge;
  - pushes presented in the flush cycle are discarded;
  - rr_ptr is kept;
  - a wb_valid already registered before the flush edge is not retracted; the reorder buffer ignores it.
- rdy low: no push, no pop, no flush, no reset of state; wb_valid holds its value. rst takes priority over rdy.
- Count width: clog2(FIFO_DEPTH)+1 bits. Each count never exceeds FIFO_DEPTH.

Decomposition:
- Shared config include gains:
  - WB_NUM_REQ;
  - WB_FIFO_DEPTH;
  - requester index constants WB_SRC_ALU = 0, WB_SRC_SLB = 1, WB_SRC_AUX = 2;
  - reuse of the existing Rob_Addr_Len, Data_Len and Addr_Len macros.
- One sub-module: wb_fifo, a single-requester skid FIFO with push, pop, count and flush. It is instantiated NUM_REQ times via generate.
- Arbitration and output registers live in the top level.

Test Plan:
- Reset, then idle: wb_valid = 0 for 10 cycles; req_ready = 3'b111 from the cycle after reset.
- Single push: ALU pushes robnum = 5, data = 32'hDEAD_BEEF at edge N -> wb_valid = 1, wb_robnum = 5, wb_src = 0 at edge N+1; wb_valid = 0 at N+2.
- Round-robin: all three units push one entry in the same cycle with robnums 1, 2, 3, rr_ptr = 0 -> writebacks on consecutive cycles in order 1, 2, 3; rr_ptr ends at 0.
- Backpressure: with no grants possible, the load/store buffer pushes 3 entries back-to-back -> req_ready[1] drops after 2 accepted; the third is held and delivered after a pop; no entry is lost or duplicated.
- Flush: queue 2 ALU entries and 1 load/store entry, assert flush for one cycle -> no wb_valid afterwards; req_ready returns to all-1 the cycle after the flush; the push presented in the flush cycle never appears.
- rdy stall: drop rdy for 3 cycles with FIFOs non-empty -> no pops and wb_valid held; order resumes unchanged when rdy returns.
